// File: rtl/ysyx_23060096_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ifu_state_e  : fetch FSM states
//   IFU_RESET_PC : default first fetch address after reset
//   IFU_NOP      : canonical RISC-V nop (addi x0, x0, 0)
//   align_word() : clears the two low address bits
package ysyx_23060096_ifu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060096_pcgen.sv
// Program counter register with next-PC selection.
//   clk, rstn : clock, asynchronous active-low reset (pc -> RESET_PC)
//   advance   : step pc by 4 (wraps modulo 2^32)
//   redirect  : load word-aligned target; wins over advance
//   target    : redirect address (low two bits ignored)
//   pc        : current fetch address
module ysyx_23060096_pcgen
  import ysyx_23060096_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = align_word(target);
    end else if (advance) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: one outstanding memory request, single-entry
// output register toward decode, redirect and halt handling.
//   clk, rstn          : clock, asynchronous active-low reset
//   imem_req_*         : fetch request (valid/ready handshake, word address)
//   imem_rsp_*         : fetch response, always accepted
//   out_valid/ready    : instruction handshake toward decode
//   out_inst, out_pc   : held instruction and its address
//   redirect_valid/pc  : branch/jump redirect pulse and target
//   halt_req, halted   : stop fetching; halted stays set until reset
module ysyx_23060096_ifu
  import ysyx_23060096_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted
);

  ifu_state_e  state_q, state_d;
  logic        drop_q, drop_d;
  logic        hpend_q, hpend_d;
  logic        req_valid_q;
  logic        out_valid_q;
  logic        halted_q;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] pc;
  logic        advance;
  logic        redirect_en;
  logic        fire;

  assign fire = req_valid_q & imem_req_ready;

  ysyx_23060096_pcgen #(
    .RESET_PC (RESET_PC)
  ) u_pcgen (
    .clk      (clk),
    .rstn     (rstn),
    .advance  (advance),
    .redirect (redirect_en),
    .target   (redirect_pc),
    .pc       (pc)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    hpend_d     = hpend_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    advance     = 1'b0;
    redirect_en = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else begin
          redirect_en = redirect_valid;
          if (fire) begin
            state_d = ST_WAIT;
            // request left with the old pc: its response must be dropped
            drop_d  = redirect_valid;
          end
        end
      end
      ST_WAIT: begin
        // A halt seen while waiting is remembered until the response lands,
        // so the memory is never left with an unmatched request.
        if (halt_req || hpend_q) begin
          if (imem_rsp_valid) begin
            state_d = ST_HALT;
            hpend_d = 1'b0;
            drop_d  = 1'b0;
          end else begin
            hpend_d = 1'b1;
          end
        end else begin
          redirect_en = redirect_valid;
          if (imem_rsp_valid) begin
            state_d = ST_FETCH;
            drop_d  = 1'b0;
            if (!drop_q && !redirect_valid) begin
              state_d    = ST_HOLD;
              out_inst_d = imem_rsp_data;
              out_pc_d   = pc;
            end
          end else if (redirect_valid) begin
            drop_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (redirect_valid) begin
          redirect_en = 1'b1;
          state_d     = ST_FETCH;
        end else if (out_ready) begin
          advance = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Outputs are registered from the next state; req_valid_q resets low so
  // the first request appears one cycle after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_FETCH;
      drop_q      <= 1'b0;
      hpend_q     <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      hpend_q     <= hpend_d;
      req_valid_q <= (state_d == ST_FETCH);
      out_valid_q <= (state_d == ST_HOLD);
      halted_q    <= (state_d == ST_HALT);
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;
  assign out_valid      = out_valid_q;
  assign out_inst       = out_inst_q;
  assign out_pc         = out_pc_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Self-checking bench for ysyx_23060096_ifu: a transaction-level model
// (outstanding request, held instruction, pc, halt) predicts the outputs
// after every clock; directed sequences add literal expectations.
module tb_ysyx_23060096_ifu;
  import ysyx_23060096_ifu_pkg::*;

  localparam logic [31:0] RP = 32'h8000_0000;

  logic        clk;
  logic        rstn;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;

  ysyx_23060096_ifu #(
    .RESET_PC (RP)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: what has been issued, what is held for decode, where the pc is.
  bit          m_started, m_halted, m_hpend, m_out, m_kill, m_held, m_fire;
  logic [31:0] m_pc, m_addr, m_inst, m_opc;

  // Memory responder state for the random phase.
  bit          mem_busy;
  int unsigned mem_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_req_valid();
    return m_started && !m_halted && !m_out && !m_held;
  endfunction

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_hpend = 0; m_out = 0; m_kill = 0;
    m_held = 0; m_fire = 0; m_pc = RP; m_addr = '0; m_inst = '0; m_opc = '0;
    mem_busy = 0; mem_lat = 0;
  endtask

  // Applies the inputs currently driven, as the next rising edge will see them.
  task automatic model_step();
    bit rsp, held_before;
    m_fire      = exp_req_valid() && imem_req_ready;
    rsp         = m_out && imem_rsp_valid;
    held_before = m_held;
    m_started   = 1;
    if (m_halted) return;
    if (halt_req) begin
      if (m_out && !rsp) m_hpend = 1;
      else begin m_halted = 1; m_out = 0; m_held = 0; end
      return;
    end
    if (m_hpend) begin
      if (rsp) begin m_halted = 1; m_out = 0; end
      return;
    end
    if (redirect_valid) begin
      m_pc   = {redirect_pc[31:2], 2'b00};
      m_held = 0;
      if (m_out) begin
        if (rsp) m_out = 0;
        else m_kill = 1;
      end
      if (m_fire) begin m_out = 1; m_kill = 1; end
      return;
    end
    if (m_fire) begin m_out = 1; m_kill = 0; m_addr = m_pc; end
    if (rsp) begin
      m_out = 0;
      if (!m_kill) begin m_held = 1; m_inst = imem_rsp_data; m_opc = m_addr; end
    end
    if (held_before && out_ready) begin
      m_held = 0;
      m_pc   = m_pc + 32'd4;
    end
  endtask

  task automatic compare();
    bit rv;
    rv = exp_req_valid();
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, rv});
    if (rv) chk("req_addr", imem_req_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_held});
    if (m_held) begin
      chk("out_inst", out_inst, m_inst);
      chk("out_pc", out_pc, m_opc);
    end
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_inputs();
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    out_ready = 0; redirect_valid = 0; redirect_pc = '0; halt_req = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, RP);
    rstn = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0;
    clear_inputs();
    model_reset();

    // Zero-wait fetch from reset.
    do_reset();
    imem_req_ready = 1; out_ready = 1;
    tick();
    chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_addr0", imem_req_addr, 32'h8000_0000);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0010_0093;
    tick();
    imem_rsp_valid = 0;
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_out_inst", out_inst, 32'h0010_0093);
    chk("t1_out_pc", out_pc, 32'h8000_0000);
    tick();
    chk("t1_next_addr", imem_req_addr, 32'h8000_0004);

    // Request stalled by memory.
    do_reset();
    tick();
    repeat (5) begin
      tick();
      chk("t2_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t2_addr", imem_req_addr, 32'h8000_0000);
      chk("t2_no_out", {31'b0, out_valid}, 32'd0);
    end

    // Redirect while waiting, then decode backpressure.
    do_reset();
    imem_req_ready = 1;
    tick(); tick();
    imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 0;
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 0;
    chk("t3_dropped", {31'b0, out_valid}, 32'd0);
    chk("t3_redir_addr", imem_req_addr, 32'h8000_0100);
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = IFU_NOP;
    tick();
    imem_rsp_valid = 0;
    chk("t3_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t3_out_pc", out_pc, 32'h8000_0100);
    repeat (4) begin
      imem_req_ready = 1;
      tick();
      chk("t4_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t4_hold_inst", out_inst, 32'h0000_0013);
      chk("t4_hold_pc", out_pc, 32'h8000_0100);
      chk("t4_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    imem_req_ready = 0; out_ready = 1;
    tick();
    out_ready = 0;
    chk("t4_next_addr", imem_req_addr, 32'h8000_0104);

    // Halt while waiting.
    do_reset();
    imem_req_ready = 1;
    tick(); tick();
    imem_req_ready = 0; halt_req = 1;
    tick();
    halt_req = 0;
    chk("t5_not_yet", {31'b0, halted}, 32'd0);
    imem_rsp_valid = 1; imem_rsp_data = $urandom;
    tick();
    imem_rsp_valid = 0;
    chk("t5_halted", {31'b0, halted}, 32'd1);
    chk("t5_no_out", {31'b0, out_valid}, 32'd0);
    imem_req_ready = 1;
    repeat (20) begin
      redirect_valid = 1'($urandom_range(0, 1)); redirect_pc = $urandom;
      tick();
      chk("t5_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    redirect_valid = 0;

    // PC wrap at the top of the address space.
    do_reset();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 0;
    chk("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = $urandom;
    tick();
    imem_rsp_valid = 0; out_ready = 1;
    chk("t6_out_pc", out_pc, 32'hFFFF_FFFC);
    tick();
    out_ready = 0;
    chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);

    // Reset in the middle of a wait; the stale response must be ignored.
    do_reset();
    imem_req_ready = 1;
    tick(); tick();
    imem_req_ready = 0;
    rstn = 0;
    #1;
    chk("t7_async_req", {31'b0, imem_req_valid}, 32'd0);
    do_reset();
    imem_rsp_valid = 1; imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 0;
    tick();
    chk("t7_stale_ignored", {31'b0, out_valid}, 32'd0);

    // Randomized traffic.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int cyc = 0; cyc < 300; cyc++) begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        out_ready      = ($urandom_range(0, 2) != 0);
        imem_rsp_valid = 0;
        if (mem_busy) begin
          if (mem_lat == 0) begin
            imem_rsp_valid = 1;
            imem_rsp_data  = $urandom;
            mem_busy       = 0;
          end else begin
            mem_lat--;
          end
        end
        redirect_valid = ($urandom_range(0, 11) == 0);
        redirect_pc    = ($urandom_range(0, 3) == 0) ?
                         (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        halt_req       = (cyc > 250) && ($urandom_range(0, 29) == 0);
        tick();
        if (m_fire) begin
          mem_busy = 1;
          mem_lat  = $urandom_range(0, 3);
        end
      end
    end

    clear_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060096_ifu.md
YSYX_23060096_IFU -- requirements
Module: ysyx_23060096_ifu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on the rising edge.
- rstn, in, 1: asynchronous active-low reset.
- imem_req_valid, out, 1: fetch request valid.
- imem_req_ready, in, 1: memory accepts the request.
- imem_req_addr, out, 32: word-aligned fetch address.
- imem_rsp_valid, in, 1: response valid; always accepted, no backpressure.
- imem_rsp_data, in, 32: fetched instruction word.
- out_valid, out, 1: instruction available to decode.
- out_ready, in, 1: decode consumes the instruction.
- out_inst, out, 32: instruction to decode.
- out_pc, out, 32: PC of out_inst.
- redirect_valid, in, 1: branch/jump redirect, one-cycle pulse.
- redirect_pc, in, 32: redirect target.
- halt_req, in, 1: ebreak seen; stop fetching.
- halted, out, 1: block is in HALT.

Function
REQ-003 The block SHALL allow at most one outstanding memory request.
REQ-004 The FSM SHALL have four states: FETCH, WAIT, HOLD and HALT.
REQ-005 In FETCH the block SHALL drive imem_req_valid=1 and imem_req_addr=pc, and SHALL go to WAIT on imem_req_valid&&imem_req_ready.
REQ-006 In WAIT, imem_rsp_valid SHALL capture imem_rsp_data into out_inst and pc into out_pc, then go to HOLD; out_valid SHALL rise the cycle after the response.
REQ-007 In HOLD the block SHALL drive out_valid=1 with out_inst and out_pc stable.
REQ-008 On out_valid&&out_ready in HOLD, pc SHALL become pc+4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0) and the FSM SHALL go to FETCH.
REQ-009 Best-case throughput SHALL be one instruction per 3 cycles (FETCH, WAIT, HOLD) with zero-wait memory.
REQ-010 A redirect SHALL set pc to {redirect_pc[31:2],2'b00}; the low two bits are ignored.
REQ-011 Redirect in FETCH, request not accepted the same cycle: the FSM SHALL stay in FETCH and the next request SHALL use the redirect address.
REQ-012 Redirect in FETCH, request accepted the same cycle: the FSM SHALL set a drop flag and go to WAIT.
REQ-013 Redirect in WAIT: the FSM SHALL set the drop flag.
REQ-014 A response arriving while the drop flag is set SHALL be discarded; the flag SHALL clear and the FSM SHALL go to FETCH. out_valid SHALL never assert for a dropped response.
REQ-015 Redirect in HOLD SHALL discard the held instruction (out_valid=0 next cycle) and go to FETCH; a simultaneous out_ready handshake SHALL still count as consumed, but pc SHALL take the redirect address, not pc+4.
REQ-016 A redirect in the same cycle as a WAIT response SHALL cause that response to be dropped.
REQ-017 halt_req sampled high SHALL prevent any new request; the FSM SHALL enter HALT from FETCH or HOLD immediately.
REQ-018 halt_req sampled high in WAIT SHALL cause the FSM to enter HALT once the outstanding response arrives, discarding that response.
REQ-019 In HALT, imem_req_valid and out_valid SHALL be 0 and halted SHALL be 1; HALT SHALL be left only by reset, and redirect_valid SHALL be ignored there.
REQ-020 halt_req SHALL take priority over redirect_valid in the same cycle.

Reset
REQ-021 While rstn=0, asynchronously: pc=RESET_PC, state=FETCH, drop flag=0, out_inst=0, out_pc=0, out_valid=0, halted=0, imem_req_valid=0.
REQ-022 imem_req_valid SHALL first assert in the first clock edge cycle after rstn deasserts.
REQ-023 Reset asserted mid-WAIT SHALL abandon the request; a response arriving after reset release, before any new request is accepted, SHALL be ignored.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the RESET_PC default, and the NOP constant 32'h0000_0013.
REQ-025 The PC register and next-PC mux SHALL be one sub-module, ysyx_23060096_pcgen (inputs: advance, redirect, target); the FSM and output register SHALL stay in the top.

Verification
REQ-026 Reset release with zero-wait memory returning 32'h0010_0093 -> req addr 8000_0000; out_valid on cycle 3 with out_inst=0010_0093, out_pc=8000_0000; next req addr 8000_0004.
REQ-027 imem_req_ready held low for 5 cycles -> imem_req_valid and addr stay stable throughout; no out_valid.
REQ-028 Redirect to 8000_0102 during WAIT -> pending response dropped; next req addr 8000_0100; out_pc=8000_0100.
REQ-029 out_ready low for 4 cycles in HOLD -> out_inst and out_pc stable; no new request until the handshake.
REQ-030 halt_req in WAIT -> response discarded; halted=1; no further requests for 20 cycles; redirect ignored.
REQ-031 PC at FFFF_FFFC consumed -> next req addr 0000_0000.
